arb_requester: RTL and testbench



---
 rtl/arb_pkg.sv | 21 ++
 rtl/arb_req_fifo.sv | 65 ++++++
 rtl/arb_requester.sv | 145 ++++++++++++++
 tb/tb_arb_requester.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the request/grant arbiter and its per-port requesters.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        XFER    = 2'b10,
        RELEASE = 2'b11
    } arb_state_e;

    localparam int ARB_DATA_W    = 8;
    localparam int ARB_DEPTH     = 4;
    localparam int ARB_BURST_MAX = 4;
    localparam int ARB_TIMEOUT   = 15;

    // Counter width able to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_req_fifo.sv
// Small synchronous FIFO buffering local words until the bus is granted.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module arb_req_fifo
    import arb_pkg::*;
#(
    parameter int DATA_W = ARB_DATA_W,
    parameter int DEPTH  = ARB_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]                   wr_ptr_q, wr_ptr_d;
    logic [AW:0]                   rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0][DATA_W-1:0]  mem_q, mem_d;
    logic                          push_fire;
    logic                          pop_fire;

    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign count     = wr_ptr_q - rd_ptr_q;
    // A full FIFO refuses the push even when a pop frees a slot this cycle.
    assign push_fire = push && !full;
    assign pop_fire  = pop && !empty;
    // Head reads as zero while empty so stale entries never leak to the bus.
    assign head      = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Next-state for storage and pointers; pointers wrap naturally mod 2*DEPTH.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_fire) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop_fire) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage and pointer registers, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/arb_requester.sv
// Per-port initiator for the two-port arbiter: buffers local words, requests
// the bus, bursts up to BURST_MAX beats per grant, gives up after TIMEOUT
// cycles without a grant, and always drops req for one cycle before re-asking.
module arb_requester
    import arb_pkg::*;
#(
    parameter int DATA_W    = ARB_DATA_W,
    parameter int DEPTH     = ARB_DEPTH,
    parameter int BURST_MAX = ARB_BURST_MAX,
    parameter int TIMEOUT   = ARB_TIMEOUT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic               req,
    input  logic               gnt,
    output logic               bus_valid,
    output logic [DATA_W-1:0]  bus_data,
    output logic               busy,
    output logic               timeout_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = cnt_w(TIMEOUT);
    localparam int BW = cnt_w(BURST_MAX + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_MAX);

    arb_state_e       state_q, state_d;
    logic             req_q, req_d;
    logic             timeout_err_q, timeout_err_d;
    logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [BW-1:0]    beat_cnt_q, beat_cnt_d;
    logic [BW-1:0]    beat_inc;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic [CW-1:0]    fifo_count;
    logic             fifo_drains;

    assign in_ready    = !fifo_full;
    assign fifo_push   = in_valid && in_ready;
    assign bus_valid   = (state_q == XFER) && gnt && !fifo_empty;
    assign busy        = (state_q != IDLE);
    assign req         = req_q;
    assign timeout_err = timeout_err_q;
    assign beat_inc    = beat_cnt_q + BW'(1);
    // The beat in flight takes the last word and nothing refills behind it.
    assign fifo_drains = (fifo_count == CW'(1)) && !fifo_push;

    arb_req_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .push   (fifo_push),
        .wdata  (in_data),
        .pop    (bus_valid),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .head   (bus_data),
        .count  (fifo_count)
    );

    // Request/transfer sequencing and the wait/beat counters.
    // beat_cnt belongs to the whole request: it is cleared when a new request
    // starts and survives a grant drop, so a resumed tenure keeps its budget.
    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        timeout_err_d = 1'b0;
        wait_cnt_d    = wait_cnt_q;
        beat_cnt_d    = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d    = REQ;
                    req_d      = 1'b1;
                    wait_cnt_d = '0;
                    beat_cnt_d = '0;
                end
            end
            REQ: begin
                if (gnt) begin
                    state_d    = XFER;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // Abandon the request; buffered words stay for the retry.
                    state_d       = RELEASE;
                    req_d         = 1'b0;
                    timeout_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            XFER: begin
                if (!gnt) begin
                    // Grant withdrawn: keep asking, restart the wait budget.
                    state_d    = REQ;
                    wait_cnt_d = '0;
                end else if (fifo_empty) begin
                    state_d = RELEASE;
                    req_d   = 1'b0;
                end else begin
                    beat_cnt_d = beat_inc;
                    if ((beat_inc == BEAT_LAST) || fifo_drains) begin
                        state_d = RELEASE;
                        req_d   = 1'b0;
                    end
                end
            end
            RELEASE: begin
                // One guaranteed low cycle so the other port can win.
                state_d = IDLE;
                req_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // FSM state, registered outputs and counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            req_q         <= 1'b0;
            timeout_err_q <= 1'b0;
            wait_cnt_q    <= '0;
            beat_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            timeout_err_q <= timeout_err_d;
            wait_cnt_q    <= wait_cnt_d;
            beat_cnt_q    <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: a scoreboard queue collects accepted
// words and every bus beat is compared against its front entry.
module tb_arb_requester;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       req;
    logic       gnt;
    logic       bus_valid;
    logic [7:0] bus_data;
    logic       busy;
    logic       timeout_err;

    int         n_chk  = 0;
    int         n_fail = 0;
    int         beats  = 0;
    int         b0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_d;
    logic       req_log  [1:20];
    logic       terr_log [1:20];
    int         req_hi;
    int         terr_cnt;

    always #5 clock = ~clock;

    arb_requester dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .req         (req),
        .gnt         (gnt),
        .bus_valid   (bus_valid),
        .bus_data    (bus_data),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    // Scoreboard: inputs are stable at the falling edge, so what is seen here
    // is what the DUT samples on the next rising edge.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus_valid) begin
                beats++;
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    exp_d = exp_q.pop_front();
                    chk("beat_data", 32'(bus_data), 32'(exp_d));
                end
            end
            if (in_valid && in_ready) exp_q.push_back(in_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        gnt      = 1'b0;
        #3;
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_bus_valid", 32'(bus_valid), 32'd0);
        chk("rst_bus_data", 32'(bus_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        tick();
        reset = 1'b0;

        // Single word, grant after three cycles in REQ.
        push(8'hA5);
        chk("t1_req_idle", 32'(req), 32'd0);
        tick();
        chk("t1_req_up", 32'(req), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        tick();
        tick();
        gnt = 1'b1;
        #1;
        chk("t1_no_beat_in_req", 32'(bus_valid), 32'd0);
        tick();
        chk("t1_beat_valid", 32'(bus_valid), 32'd1);
        chk("t1_beat_head", 32'(bus_data), 32'hA5);
        tick();
        gnt = 1'b0;
        chk("t1_release_req", 32'(req), 32'd0);
        chk("t1_release_busy", 32'(busy), 32'd1);
        tick();
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_idle_data", 32'(bus_data), 32'd0);
        chk("t1_beats", 32'(beats), 32'd1);
        chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

        // Full FIFO, burst limited to BURST_MAX beats.
        for (int i = 1; i <= 4; i++) push(8'(i));
        chk("t2_in_ready_full", 32'(in_ready), 32'd0);
        chk("t2_head", 32'(bus_data), 32'h01);
        gnt = 1'b1;
        tick();
        b0 = beats;
        for (int i = 0; i < 4; i++) begin
            chk("t2_beat_valid", 32'(bus_valid), 32'd1);
            tick();
        end
        chk("t2_release_req", 32'(req), 32'd0);
        chk("t2_release_bv", 32'(bus_valid), 32'd0);
        chk("t2_beats", 32'(beats - b0), 32'd4);
        gnt = 1'b0;
        tick();
        chk("t2_idle_busy", 32'(busy), 32'd0);
        chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // Refill during the burst, second tenure carries the late words.
        for (int i = 1; i <= 4; i++) push(8'(i));
        gnt = 1'b1;
        b0 = beats;
        tick();
        tick();
        chk("t3_space_open", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = 8'h05;
        tick();
        in_data  = 8'h06;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t3_release_req", 32'(req), 32'd0);
        chk("t3_first_tenure", 32'(beats - b0), 32'd4);
        tick();
        chk("t3_idle_req", 32'(req), 32'd0);
        chk("t3_idle_busy", 32'(busy), 32'd0);
        tick();
        chk("t3_rereq", 32'(req), 32'd1);
        chk("t3_rereq_bv", 32'(bus_valid), 32'd0);
        tick();
        chk("t3_second_valid", 32'(bus_valid), 32'd1);
        chk("t3_second_head", 32'(bus_data), 32'h05);
        tick();
        tick();
        chk("t3_second_release", 32'(req), 32'd0);
        chk("t3_total_beats", 32'(beats - b0), 32'd6);
        gnt = 1'b0;
        tick();
        chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // No grant: request abandoned after TIMEOUT cycles, word retained.
        push(8'h33);
        for (int i = 1; i <= 20; i++) begin
            tick();
            req_log[i]  = req;
            terr_log[i] = timeout_err;
        end
        req_hi   = 0;
        terr_cnt = 0;
        for (int i = 1; i <= 15; i++) req_hi += int'(req_log[i]);
        for (int i = 1; i <= 20; i++) terr_cnt += int'(terr_log[i]);
        chk("t4_req_high_cycles", 32'(req_hi), 32'd15);
        chk("t4_req_drop", 32'(req_log[16]), 32'd0);
        chk("t4_terr_pos", 32'(terr_log[16]), 32'd1);
        chk("t4_terr_pulses", 32'(terr_cnt), 32'd1);
        chk("t4_idle_low", 32'(req_log[17]), 32'd0);
        chk("t4_rereq", 32'(req_log[18]), 32'd1);
        chk("t4_head_kept", 32'(bus_data), 32'h33);
        gnt = 1'b1;
        tick();
        tick();
        gnt = 1'b0;
        tick();
        chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // Grant drops after two beats for three cycles, then resumes.
        for (int i = 1; i <= 4; i++) push(8'h10 + 8'(i));
        gnt = 1'b1;
        tick();
        b0 = beats;
        tick();
        tick();
        gnt = 1'b0;
        #1;
        chk("t5_drop_bv0", 32'(bus_valid), 32'd0);
        chk("t5_drop_req0", 32'(req), 32'd1);
        chk("t5_two_beats", 32'(beats - b0), 32'd2);
        tick();
        chk("t5_drop_req1", 32'(req), 32'd1);
        chk("t5_drop_bv1", 32'(bus_valid), 32'd0);
        tick();
        chk("t5_drop_req2", 32'(req), 32'd1);
        gnt = 1'b1;
        #1;
        chk("t5_regnt_no_beat", 32'(bus_valid), 32'd0);
        chk("t5_no_beats_in_drop", 32'(beats - b0), 32'd2);
        tick();
        chk("t5_resume_valid", 32'(bus_valid), 32'd1);
        chk("t5_resume_head", 32'(bus_data), 32'h13);
        tick();
        tick();
        chk("t5_end_req", 32'(req), 32'd0);
        chk("t5_beats", 32'(beats - b0), 32'd4);
        gnt = 1'b0;
        tick();
        chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a burst.
        for (int i = 1; i <= 3; i++) push(8'h20 + 8'(i));
        gnt = 1'b1;
        tick();
        tick();
        chk("t6_second_beat", 32'(bus_valid), 32'd1);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("t6_rst_req", 32'(req), 32'd0);
        chk("t6_rst_bv", 32'(bus_valid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_ready", 32'(in_ready), 32'd1);
        chk("t6_rst_data", 32'(bus_data), 32'd0);
        b0 = beats;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("t6_no_beats", 32'(beats - b0), 32'd0);
        chk("t6_busy_after", 32'(busy), 32'd0);
        chk("t6_req_after", 32'(req), 32'd0);
        gnt = 1'b0;
        chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
